// File: rtl/utemporal_pkg.sv
// utemporal_pkg: shared types and constants for the temporal multiplier controller.
//   DefaultWidth  - default signed data width (operand magnitudes are DefaultWidth-1 bits)
//   ctrl_state_e  - controller FSM state encoding
package utemporal_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } ctrl_state_e;

endpackage

// File: rtl/utemporal_mul_ctrl.sv
// utemporal_mul_ctrl: job controller for a temporal/rate-coded unary multiplier.
// Accepts one job (input and weight magnitudes), pulses mul_init to load the
// multiplier, counts product ones for a run of L cycles, then presents the count.
//
// Ports:
//   clk, rst               - clock (rising edge) and synchronous active-high reset
//   in_valid / in_ready    - job request handshake; in_data_i / in_data_w operand magnitudes
//   abort                  - cancels the current job (ignored while idle)
//   mul_init, mul_clr      - load pulse and clear to the multiplier (never together)
//   mul_data_i, mul_data_w - registered operands to the multiplier
//   mul_bit                - product bit from the multiplier
//   out_valid / out_ready  - result handshake; out_acc saturating count of mul_bit ones
//   busy                   - high whenever the controller is not idle
//
// Build option: define UTEMPORAL_EARLY_TERM_EN to make the run length equal to the
// input magnitude (zero input skips the run). Otherwise every job runs RUN_LEN cycles.
module utemporal_mul_ctrl
    import utemporal_pkg::*;
#(
    parameter int unsigned WIDTH   = DefaultWidth,
    parameter int unsigned RUN_LEN = 2 ** (WIDTH - 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-2:0] in_data_i,
    input  logic [WIDTH-2:0] in_data_w,
    input  logic             abort,
    output logic             mul_init,
    output logic             mul_clr,
    output logic [WIDTH-2:0] mul_data_i,
    output logic [WIDTH-2:0] mul_data_w,
    input  logic             mul_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-2:0] out_acc,
    output logic             busy
);

    localparam int unsigned MagW    = WIDTH - 1;
    localparam int unsigned RunCntW = $clog2(RUN_LEN + 1);
    // Counter must hold either the fixed run length or an operand magnitude.
    localparam int unsigned CntW    = (RunCntW > MagW) ? RunCntW : MagW;

    localparam logic [MagW-1:0] AccMax  = '1;
    localparam logic [CntW-1:0] RunLenC = CntW'(RUN_LEN);

    ctrl_state_e     state_q, state_d;
    logic [MagW-1:0] acc_q, acc_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [MagW-1:0] data_i_q, data_i_d;
    logic [MagW-1:0] data_w_q, data_w_d;
    logic [CntW-1:0] run_len;

`ifdef UTEMPORAL_EARLY_TERM_EN
    assign run_len = CntW'(data_i_q);
`else
    assign run_len = RunLenC;
`endif

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        data_i_d  = data_i_q;
        data_w_d  = data_w_q;
        in_ready  = 1'b0;
        mul_init  = 1'b0;
        mul_clr   = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            StIdle: begin
                // Held off during reset so no job is advertised until rst drops.
                in_ready = ~rst;
                if (in_valid) begin
                    data_i_d = in_data_i;
                    data_w_d = in_data_w;
                    acc_d    = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (abort) begin
                    mul_clr = 1'b1;
                    state_d = StIdle;
                end else begin
                    mul_init = 1'b1;
                    cnt_d    = run_len;
                    state_d  = (run_len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    mul_clr = 1'b1;
                    state_d = StIdle;
                end else begin
                    if (mul_bit && (acc_q != AccMax)) begin
                        acc_d = acc_q + MagW'(1);
                    end
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                mul_clr = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_i_q <= '0;
            data_w_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            data_i_q <= data_i_d;
            data_w_q <= data_w_d;
        end
    end

    assign mul_data_i = data_i_q;
    assign mul_data_w = data_w_q;
    assign out_acc    = acc_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_utemporal_mul_ctrl.sv
// tb_utemporal_mul_ctrl: self-checking bench for utemporal_mul_ctrl (WIDTH=9, RUN_LEN=256).
// A small behavioural multiplier drives mul_bit: product bit is high for run cycle t when
// t < i and a Bresenham rate sequence for w emits a one, so n cycles give floor(n*w/256)
// ones from the first min(n,i) cycles. A "ones" mode forces mul_bit high for saturation.
module tb_utemporal_mul_ctrl;

    localparam int unsigned W  = 9;
    localparam int unsigned RL = 256;
    localparam int unsigned Timeout = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-2:0] in_data_i;
    logic [W-2:0] in_data_w;
    logic         abort;
    logic         mul_init;
    logic         mul_clr;
    logic [W-2:0] mul_data_i;
    logic [W-2:0] mul_data_w;
    logic         mul_bit;
    logic         out_valid;
    logic         out_ready;
    logic [W-2:0] out_acc;
    logic         busy;

    utemporal_mul_ctrl #(
        .WIDTH   (W),
        .RUN_LEN (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data_i  (in_data_i),
        .in_data_w  (in_data_w),
        .abort      (abort),
        .mul_init   (mul_init),
        .mul_clr    (mul_clr),
        .mul_data_i (mul_data_i),
        .mul_data_w (mul_data_w),
        .mul_bit    (mul_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_acc    (out_acc),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier
    logic [8:0] t_q  = '1;
    logic [7:0] mi_q = '0;
    logic [7:0] mw_q = '0;
    logic       ones_mode = 1'b0;

    always_ff @(posedge clk) begin
        if (mul_init) begin
            t_q  <= '0;
            mi_q <= mul_data_i;
            mw_q <= mul_data_w;
        end else if (t_q != 9'h1ff) begin
            t_q <= t_q + 9'd1;
        end
    end

    function automatic logic model_bit(input logic [8:0] t, input logic [7:0] mi,
                                       input logic [7:0] mw, input logic ones);
        int unsigned a;
        int unsigned b;
        if (ones) return 1'b1;
        a = ((32'(t) + 1) * 32'(mw)) / 256;
        b = (32'(t) * 32'(mw)) / 256;
        return (32'(t) < 32'(mi)) && (a != b);
    endfunction

    assign mul_bit = model_bit(t_q, mi_q, mw_q, ones_mode);

    // Sticky monitors
    logic init_clr_both = 1'b0;
    logic stray_valid   = 1'b0;
    logic watch_valid   = 1'b0;

    always @(negedge clk) begin
        if (mul_init === 1'b1 && mul_clr === 1'b1) init_clr_both = 1'b1;
        if (watch_valid && out_valid !== 1'b0) stray_valid = 1'b1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input logic [7:0] i);
`ifdef UTEMPORAL_EARLY_TERM_EN
        return 2 + int'(i);
`else
        return 2 + int'(RL);
`endif
    endfunction

    // Handshake a job; returns in cycle N+1 (LOAD) with in_valid dropped.
    task automatic start_job(input logic [7:0] i, input logic [7:0] w);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data_i = i;
        in_data_w = w;
        @(negedge clk);
        in_valid = 1'b0;
        check("load_mul_init", 32'(mul_init), 32'd1);
        check("load_busy", 32'(busy), 32'd1);
        check("load_in_ready", 32'(in_ready), 32'd0);
        check("mul_data_i", 32'(mul_data_i), 32'(i));
        check("mul_data_w", 32'(mul_data_w), 32'(w));
    endtask

    // Called in cycle N+1; returns k such that out_valid was seen in cycle N+k.
    task automatic wait_done(output int k);
        k = 1;
        while (out_valid !== 1'b1 && k < Timeout) begin
            @(negedge clk);
            k++;
        end
        if (out_valid !== 1'b1) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    typedef struct {
        logic [7:0] i;
        logic [7:0] w;
        logic       ones;
        logic [7:0] acc;
        int         hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int k;
        logic [7:0] acc_snap;

        vecs[0] = '{8'd0,   8'd255, 1'b0, 8'd0,   0};
        vecs[1] = '{8'd128, 8'd255, 1'b0, 8'd127, 0};
        vecs[2] = '{8'd128, 8'd0,   1'b0, 8'd0,   0};
        vecs[3] = '{8'd255, 8'd0,   1'b1, 8'd255, 0};   // all-ones run saturates at 255
        vecs[4] = '{8'd64,  8'd128, 1'b0, 8'd32,  10};  // consumer stalls 10 cycles
        vecs[5] = '{8'd200, 8'd64,  1'b0, 8'd50,  0};

        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data_i = 8'd5;
        in_data_w = 8'd7;
        abort     = 1'b0;
        out_ready = 1'b0;

        // Reset with a pending request
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mul_init", 32'(mul_init), 32'd0);
        check("rst_mul_clr", 32'(mul_clr), 32'd0);
        check("rst_out_acc", 32'(out_acc), 32'd0);
        check("rst_mul_data_i", 32'(mul_data_i), 32'd0);
        check("rst_mul_data_w", 32'(mul_data_w), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table-driven jobs
        for (int v = 0; v < 6; v++) begin
            ones_mode = vecs[v].ones;
            start_job(vecs[v].i, vecs[v].w);
            wait_done(k);
            check("latency", 32'(k), 32'(exp_latency(vecs[v].i)));
            check("out_acc", 32'(out_acc), 32'(vecs[v].acc));
            check("done_mul_clr", 32'(mul_clr), 32'd1);
            acc_snap = out_acc;
            for (int h = 0; h < vecs[v].hold; h++) begin
                @(negedge clk);
                check("hold_out_valid", 32'(out_valid), 32'd1);
                check("hold_out_acc", 32'(out_acc), 32'(acc_snap));
                check("hold_mul_init", 32'(mul_init), 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("after_out_valid", 32'(out_valid), 32'd0);
            check("after_in_ready", 32'(in_ready), 32'd1);
            check("after_busy", 32'(busy), 32'd0);
        end
        ones_mode = 1'b0;

        // Abort in the 5th RUN cycle (RUN cycles are N+2..)
        start_job(8'd128, 8'd255);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_run_mul_clr", 32'(mul_clr), 32'd1);
        check("abort_run_out_valid", 32'(out_valid), 32'd0);
        check("abort_run_mul_init", 32'(mul_init), 32'd0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_run_in_ready", 32'(in_ready), 32'd1);
        check("abort_run_busy", 32'(busy), 32'd0);
        watch_valid = 1'b1;
        repeat (300) @(negedge clk);
        watch_valid = 1'b0;
        check("abort_run_no_result", 32'(stray_valid), 32'd0);

        // Abort during LOAD: clear wins, init suppressed
        start_job(8'd10, 8'd10);
        abort = 1'b1;
        #1;
        check("abort_load_mul_init", 32'(mul_init), 32'd0);
        check("abort_load_mul_clr", 32'(mul_clr), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_load_in_ready", 32'(in_ready), 32'd1);

        // Abort coinciding with a request in IDLE: job is accepted
        in_valid  = 1'b1;
        abort     = 1'b1;
        in_data_i = 8'd3;
        in_data_w = 8'd9;
        #1;
        check("idle_abort_mul_clr", 32'(mul_clr), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        #1;
        check("idle_abort_busy", 32'(busy), 32'd1);
        check("idle_abort_mul_init", 32'(mul_init), 32'd1);
        check("idle_abort_mul_data_i", 32'(mul_data_i), 32'd3);

        // Let it finish, then abort in DONE
        wait_done(k);
        check("job3_latency", 32'(k), 32'(exp_latency(8'd3)));
        abort = 1'b1;
        #1;
        check("abort_done_out_valid", 32'(out_valid), 32'd0);
        check("abort_done_mul_clr", 32'(mul_clr), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_done_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-job drops the job silently
        start_job(8'd100, 8'd100);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_acc", 32'(out_acc), 32'd0);
        check("midrst_mul_data_i", 32'(mul_data_i), 32'd0);
        stray_valid = 1'b0;
        watch_valid = 1'b1;
        repeat (300) @(negedge clk);
        watch_valid = 1'b0;
        check("midrst_no_result", 32'(stray_valid), 32'd0);

        check("init_clr_exclusive", 32'(init_clr_both), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
